// File: rtl/kmeans_pkg.sv
// Shared definitions for the k-means accelerator: default sizes, width
// derivations, controller state encoding and centroid element indexing.
package kmeans_pkg;

    localparam int K_DEF    = 8;
    localparam int D_DEF    = 4;
    localparam int W_DEF    = 8;
    localparam int NMAX_DEF = 255;

    // Bits needed to index n items, never less than one.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int lw_f(input int k);
        return idx_w(k);
    endfunction

    function automatic int cw_f(input int nmax);
        return $clog2(nmax + 1);
    endfunction

    function automatic int sw_f(input int w, input int nmax);
        return w + cw_f(nmax);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Flat element index of (cluster k, dimension d); slice is [idx*W +: W].
    function automatic int elem_idx(input int k, input int d, input int dims);
        return k * dims + d;
    endfunction

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider: one load cycle, then SW shift/subtract cycles.
// quotient is valid combinationally while q_valid is high.
module serial_divider
    import kmeans_pkg::*;
#(
    parameter  int SW = 16,
    localparam int IW = idx_w(SW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [SW-1:0] dividend,
    input  logic [SW-1:0] divisor,
    output logic          busy,
    output logic          q_valid,
    output logic [SW-1:0] quotient
);

    logic [SW-1:0] rem_r;
    logic [SW-1:0] q_r;
    logic [SW-1:0] dvs_r;
    logic [IW-1:0] it_r;
    logic          busy_r;

    logic [SW:0]   shifted_s;
    logic [SW:0]   diff_s;
    logic          qbit_s;
    logic [SW-1:0] rem_next_s;

    // Trial subtraction for the current quotient bit.
    always_comb begin
        shifted_s  = {rem_r, q_r[SW-1]};
        diff_s     = shifted_s - {1'b0, dvs_r};
        qbit_s     = ~diff_s[SW];
        rem_next_s = qbit_s ? diff_s[SW-1:0] : shifted_s[SW-1:0];
    end

    // Divider datapath and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r  <= '0;
            q_r    <= '0;
            dvs_r  <= '0;
            it_r   <= '0;
            busy_r <= 1'b0;
        end else if (load) begin
            rem_r  <= '0;
            q_r    <= dividend;
            dvs_r  <= divisor;
            it_r   <= '0;
            busy_r <= 1'b1;
        end else if (busy_r) begin
            rem_r  <= rem_next_s;
            q_r    <= {q_r[SW-2:0], qbit_s};
            it_r   <= it_r + IW'(1);
            busy_r <= (it_r != IW'(SW - 1));
        end
    end

    assign busy     = busy_r;
    assign q_valid  = busy_r && (it_r == IW'(SW - 1));
    assign quotient = {q_r[SW-2:0], qbit_s};

endmodule

// File: rtl/centroid_update.sv
// k-means centroid update: accumulates labelled points per cluster, then
// serially divides each sum by its count to form new_c (empty clusters keep old_c).
module centroid_update
    import kmeans_pkg::*;
#(
    parameter  int K    = K_DEF,
    parameter  int D    = D_DEF,
    parameter  int W    = W_DEF,
    parameter  int NMAX = NMAX_DEF,
    localparam int LW   = lw_f(K),
    localparam int CW   = cw_f(NMAX),
    localparam int SW   = sw_f(W, NMAX)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pt_valid,
    output logic             pt_ready,
    input  logic [D*W-1:0]   pt_data,
    input  logic [LW-1:0]    pt_label,
    input  logic             pt_last,
    input  logic [K*D*W-1:0] old_c,
    output logic [K*D*W-1:0] new_c,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int DW = idx_w(D);

    state_e              state_r;
    logic                pt_ready_r, busy_r, done_r, overflow_r, load_r;
    logic [K*D*W-1:0]    new_c_r;
    logic signed [SW-1:0] sum_r [K][D];
    logic [CW-1:0]       cnt_r [K];
    logic [CW-1:0]       tot_r;
    logic [LW-1:0]       k_r;
    logic [DW-1:0]       d_r;

    logic                hs_s, clr_s, lab_ok_s, room_s, add_s, drop_ovf_s, last_elem_s;
    logic                div_busy_s, q_valid_s;
    int                  e_s;
    logic signed [SW-1:0] cur_sum_s;
    logic [SW-1:0]       mag_s, quot_s;
    logic [W-1:0]        quot_w_s, res_s;

    // Handshake qualification and sign / empty-cluster selection for the divider.
    always_comb begin
        hs_s        = pt_valid && pt_ready_r;
        clr_s       = (state_r == ST_IDLE) && start;
        lab_ok_s    = 32'(pt_label) < K;
        room_s      = tot_r < CW'(NMAX);
        add_s       = hs_s && lab_ok_s && room_s;
        drop_ovf_s  = hs_s && lab_ok_s && !room_s;
        e_s         = elem_idx(int'(k_r), int'(d_r), D);
        last_elem_s = (32'(k_r) == K - 1) && (32'(d_r) == D - 1);
        cur_sum_s   = sum_r[k_r][d_r];
        mag_s       = cur_sum_s[SW-1] ? $unsigned(-cur_sum_s) : $unsigned(cur_sum_s);
        // Upper quotient bits are zero for any legal sum; clamp defensively.
        quot_w_s    = (|quot_s[SW-1:W]) ? {1'b1, {(W-1){1'b0}}} : quot_s[W-1:0];
        res_s       = (cnt_r[k_r] == CW'(0)) ? old_c[e_s*W +: W]
                    : (cur_sum_s[SW-1] ? (~quot_w_s + W'(1)) : quot_w_s);
    end

    serial_divider #(.SW(SW)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_r && !div_busy_s),
        .dividend (mag_s),
        .divisor  ({{(SW-CW){1'b0}}, cnt_r[k_r]}),
        .busy     (div_busy_s),
        .q_valid  (q_valid_s),
        .quotient (quot_s)
    );

    // Per-cluster coordinate sums, point counts and the iteration total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < K; k++) begin
                cnt_r[k] <= '0;
                for (int d = 0; d < D; d++) sum_r[k][d] <= '0;
            end
            tot_r <= '0;
        end else if (clr_s) begin
            for (int k = 0; k < K; k++) begin
                cnt_r[k] <= '0;
                for (int d = 0; d < D; d++) sum_r[k][d] <= '0;
            end
            tot_r <= '0;
        end else if (add_s) begin
            for (int k = 0; k < K; k++) begin
                if (pt_label == LW'(k)) begin
                    cnt_r[k] <= cnt_r[k] + CW'(1);
                    for (int d = 0; d < D; d++)
                        sum_r[k][d] <= sum_r[k][d] + SW'(signed'(pt_data[d*W +: W]));
                end
            end
            tot_r <= tot_r + CW'(1);
        end
    end

    // Control FSM, element walk and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            pt_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
            load_r     <= 1'b0;
            new_c_r    <= '0;
            k_r        <= '0;
            d_r        <= '0;
        end else begin
            done_r <= 1'b0;
            if (drop_ovf_s) overflow_r <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_ACCUM;
                        pt_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                        overflow_r <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (hs_s && pt_last) begin
                        state_r    <= ST_DIVIDE;
                        pt_ready_r <= 1'b0;
                        k_r        <= '0;
                        d_r        <= '0;
                        load_r     <= 1'b1;
                    end
                end
                ST_DIVIDE: begin
                    load_r <= 1'b0;
                    if (q_valid_s) begin
                        new_c_r[e_s*W +: W] <= res_s;
                        if (last_elem_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            load_r <= 1'b1;
                            if (32'(d_r) == D - 1) begin
                                d_r <= '0;
                                k_r <= k_r + LW'(1);
                            end else begin
                                d_r <= d_r + DW'(1);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign pt_ready = pt_ready_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign overflow = overflow_r;
    assign new_c    = new_c_r;

endmodule

// File: doc/centroid_update.md
# centroid_update

Sequential centroid-update engine for the k-means accelerator. It consumes the stream of labelled points produced by the assignment stage, accumulates per-cluster coordinate sums and counts, and divides to produce the new centroid set `new_c`. The convergence comparator then checks `new_c` against `old_c` at the end of each iteration. Clusters that receive no points carry their `old_c` value forward unchanged.

## Interface
- `K`, default 8: number of clusters.
- `D`, default 4: dimensions per point.
- `W`, default 8: signed coordinate width.
- `NMAX`, default 255: maximum points per iteration.
- Derived: `LW = $clog2(K)`; `CW = $clog2(NMAX+1)`; sum width `SW = W+CW`.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: begin an iteration by clearing the accumulators. Honoured only in IDLE.
- `pt_valid`, input, 1: point beat valid.
- `pt_ready`, output, 1: high only in ACCUM.
- `pt_data`, input, D*W: signed coordinates; dimension d is at `[d*W +: W]`.
- `pt_label`, input, LW: cluster index of the point.
- `pt_last`, input, 1: marks the final point of the iteration.
- `old_c`, input, K*D*W: current centroids. Element `(k*D+d)*W +: W`. Must be stable from `start` until `done`.
- `new_c`, output, K*D*W: updated centroids, registered, same packing as `old_c`.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse when `new_c` is complete.
- `overflow`, output, 1: sticky. Set when a point beyond NMAX is received; cleared by `start`.

## Operation
- States: IDLE, ACCUM, DIVIDE, DONE.
- IDLE, when `start` is high:
  - Clear all K*D sums, all K counts and `overflow`.
  - Go to ACCUM.
- ACCUM:
  - A handshake is `pt_valid && pt_ready`.
  - On each handshake with `pt_label < K` and total accepted count < NMAX:
    - Each `sum[label][d]` += sign-extended `pt_data[d]`.
    - `cnt[label]` += 1.
  - `pt_label >= K`: the beat is accepted and discarded.
  - Total already at NMAX: the beat is accepted and discarded, and `overflow` is set.
  - A handshake with `pt_last` high is processed as above, then the block goes to DIVIDE.
  - `pt_last` with `pt_valid` low has no effect.
- DIVIDE:
  - Walks element index e = 0 .. K*D-1, with k = e/D and d = e%D.
  - For each element, one load cycle, then SW iterations of restoring division on |sum| / cnt.
  - Quotient sign = sign of sum; the result truncates toward zero.
  - The quotient magnitude is always ≤ 2^(W-1), so the W-bit result never overflows.
  - `cnt[k] == 0`: the divider still runs its full cycles (fixed latency), and `old_c` element e is written instead of the quotient.
  - `new_c` element e is written on the last iteration cycle for e.
  - After e = K*D-1, go to DONE.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- `start` outside IDLE is ignored.
- `new_c` holds its value between `done` pulses.
- Elements not yet rewritten during DIVIDE keep their previous-iteration value.

## Timing
- Reset values:
  - State = IDLE.
  - `pt_ready`, `busy`, `done`, `overflow` = 0.
  - `new_c` = 0.
  - Sums, counts and divider registers = 0.
- `start` sampled high → `pt_ready` = 1 on the next cycle.
- Accumulation is single-cycle per beat with no stalls: throughput is one point per clock.
- Final handshake (`pt_last`) at cycle T:
  - DIVIDE occupies cycles T+1 .. T+K*D*(SW+1).
  - `done` is high at cycle T+K*D*(SW+1)+1.
  - With defaults (SW = 16), `done` is at T+545.
- `pt_ready` falls the cycle after the `pt_last` handshake.
- Reset asserted mid-operation returns everything to its reset values immediately (asynchronous). No partial `done` is produced.

## Structure
- Package `kmeans_pkg` holds:
  - the shared K/D/W defaults;
  - `SW`/`CW`/`LW` derivation functions;
  - the state enum;
  - an element-index helper shared with the comparator.
- Sub-module `serial_divider`:
  - SW-bit unsigned restoring divider;
  - `load`/`busy`/`q_valid` interface;
  - latency 1 + SW cycles.
- The sign handling and the empty-cluster mux stay in `centroid_update`.

## Test plan
- Basic mean: K = 2, D = 1. Points (10, L0), (20, L0), (31, L0, last). Expect `new_c[0]` = 20 (61/3 truncated), `new_c[1]` = `old_c[1]`, and `done` exactly K*D*(SW+1)+1 cycles after `last`.
- Negative truncation: points -7 and -8 to cluster 1. Expect -7 (-15/2 → -7, not -8). Points -128 and -128 → -128.
- Empty cluster: `old_c` all 0x11. Feed all points to cluster 0. Expect clusters 1..K-1 = 0x11 and cluster 0 = the mean.
- Overflow and bad label:
  - NMAX = 3, feed 5 points: the last 2 are ignored in the sums and `overflow` = 1.
  - A point with label ≥ K is ignored with no `overflow`.
  - A later `start` clears `overflow`.
- Control robustness:
  - `start` pulsed during ACCUM and during DIVIDE: no effect.
  - `pt_valid` gaps between points give the same result as back-to-back points.
- Reset mid-DIVIDE:
  - Assert `rst_n` = 0 for 1 cycle at e = 3. Expect `new_c` = 0, IDLE, and no `done` pulse.
  - A fresh iteration afterwards gives correct results.
